ahb_sram_slave: RTL and testbench

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_sram_slave.sv | 149 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-wide storage split into four byte lanes, with
// per-lane write enables, configurable wait states and a two-cycle ERROR response.

module ahb_sram_lane #(
  parameter int ADDR_LOG2 = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_LOG2-1:0] idx,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  logic [7:0] mem [2**ADDR_LOG2];

  // No reset: contents survive HRESETn.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module ahb_sram_slave #(
  parameter int ADDR_LOG2   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int AW = ADDR_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  typedef struct packed {
    logic          vld;
    logic          write;
    logic [1:0]    size;
    logic [AW-1:0] addr;
  } xfer_t;

  state_t             state, state_nxt;
  logic [2:0]         cnt, cnt_nxt;
  xfer_t              dp, dp_nxt;
  logic               accept, legal, commit;
  logic [3:0]         be;
  logic [3:0][7:0]    word;
  logic [ADDR_LOG2-1:0] widx;
  logic               unused;

  assign unused = ^{HADDR[31:AW], HTRANS[0]};

  // ERR2 already drives HREADYOUT high, so the next address phase lands there.
  assign accept = HSEL & HREADY & HTRANS[1] & ((state == IDLE) | (state == ERR2));

  always_comb begin
    legal = 1'b0;
    case (HSIZE)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~HADDR[0];
      3'd2:    legal = (HADDR[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dp_nxt    = dp;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      IDLE, ERR2: begin
        HRESP     = (state == ERR2);
        state_nxt = IDLE;
        dp_nxt.vld = 1'b0;
        if (accept) begin
          dp_nxt.vld   = legal;
          dp_nxt.write = HWRITE;
          dp_nxt.size  = HSIZE[1:0];
          dp_nxt.addr  = HADDR[AW-1:0];
          if (!legal) begin
            state_nxt = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 3'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt == 3'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 3'd1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= 3'd0;
      dp    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dp    <= dp_nxt;
    end
  end

  // Write lands on the edge that ends the data phase, i.e. while back in IDLE.
  assign commit = dp.vld & dp.write & (state == IDLE);
  assign widx   = dp.addr[AW-1:2];

  always_comb begin
    be = 4'b0000;
    case (dp.size)
      2'd0:    be = 4'b0001 << dp.addr[1:0];
      2'd1:    be = dp.addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    ahb_sram_lane #(.ADDR_LOG2(ADDR_LOG2)) u_lane (
      .clk   (HCLK),
      .we    (commit & be[g]),
      .idx   (widx),
      .wdata (HWDATA[8*g +: 8]),
      .rdata (word[g])
    );
  end

  assign HRDATA = (dp.vld & ~dp.write) ? word : 32'h0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (no-wait, 3-wait, 16-word) driven by a
// pipelined AHB master; a byte-array model predicts every cycle's outputs.
module tb_ahb_sram_slave;
  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  typedef struct packed {
    logic rdy;
    logic resp;
    logic rd;
    logic commit;
    vec_t v;
  } exp_t;

  localparam logic [1:0] NS = 2'b10, BZ = 2'b01;

  logic [2:0]  sel, rst_n, rdyo, resp;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] rdata [3];

  int          checks = 0, errors = 0;
  int          lowcnt [3];
  int          respcnt [3];
  logic [31:0] last_rd [3];
  logic [7:0]  mm [3][4096];
  vec_t        seq [$];
  exp_t        exq [3][$];

  ahb_sram_slave #(.ADDR_LOG2(10), .WAIT_STATES(0)) u0 (
    .HCLK(HCLK), .HRESETn(rst_n[0]), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdyo[0]),
    .HRDATA(rdata[0]), .HREADYOUT(rdyo[0]), .HRESP(resp[0]));
  ahb_sram_slave #(.ADDR_LOG2(10), .WAIT_STATES(3)) u1 (
    .HCLK(HCLK), .HRESETn(rst_n[1]), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdyo[1]),
    .HRDATA(rdata[1]), .HREADYOUT(rdyo[1]), .HRESP(resp[1]));
  ahb_sram_slave #(.ADDR_LOG2(4), .WAIT_STATES(0)) u2 (
    .HCLK(HCLK), .HRESETn(rst_n[2]), .HSEL(sel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdyo[2]),
    .HRDATA(rdata[2]), .HREADYOUT(rdyo[2]), .HRESP(resp[2]));

  function automatic int al(int k); return (k == 2) ? 4 : 10; endfunction
  function automatic int ws(int k); return (k == 1) ? 3 : 0;  endfunction

  function automatic int ba(int k, logic [31:0] a);
    return int'(a) & ((1 << (al(k) + 2)) - 1);
  endfunction

  function automatic bit legal(vec_t v);
    return (v.size == 3'd0) || (v.size == 3'd1 && !v.addr[0]) ||
           (v.size == 3'd2 && v.addr[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] mword(int k, logic [31:0] a);
    int b;
    b = ba(k, a) & ~3;
    return {mm[k][b+3], mm[k][b+2], mm[k][b+1], mm[k][b]};
  endfunction

  function automatic void mwrite(int k, vec_t v);
    int n, b;
    n = (v.size == 3'd0) ? 1 : (v.size == 3'd1) ? 2 : 4;
    b = ba(k, v.addr);
    for (int j = 0; j < n; j++) mm[k][b+j] = v.data[8*j +: 8];
  endfunction

  // Value placed on its byte lanes; unused lanes carry filler that must never be stored.
  function automatic logic [31:0] hw(vec_t v);
    logic [31:0] m;
    int sh;
    m  = (v.size == 3'd0) ? 32'hFF : (v.size == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh = 8 * int'(v.addr[1:0]);
    return ((v.data & m) << sh) | (32'hA5A5_A5A5 & ~(m << sh));
  endfunction

  function automatic vec_t mk(logic [1:0] t, logic w, logic [2:0] s, logic [31:0] a, logic [31:0] d);
    vec_t v;
    v.trans = t; v.wr = w; v.size = s; v.addr = a; v.data = d;
    return v;
  endfunction

  task automatic push_exp(int k, vec_t v);
    if (legal(v)) begin
      for (int j = 0; j < ws(k); j++) exq[k].push_back('{1'b0, 1'b0, !v.wr, 1'b0, v});
      exq[k].push_back('{1'b1, 1'b0, !v.wr, v.wr, v});
    end else begin
      exq[k].push_back('{1'b0, 1'b1, 1'b0, 1'b0, v});
      exq[k].push_back('{1'b1, 1'b1, 1'b0, 1'b0, v});
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic drive_addr(int k, int i);
    sel = 3'b000;
    sel[k] = 1'b1;
    if (i < seq.size()) begin
      haddr = seq[i].addr; htrans = seq[i].trans; hwrite = seq[i].wr; hsize = seq[i].size;
    end else begin
      haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
    end
  endtask

  // Pipelined master: an address phase advances only on an edge where HREADY was high.
  task automatic run_seq(int k);
    int   i, guard;
    logic rdy;
    vec_t dp;
    i = 0; guard = 0;
    @(posedge HCLK); #1;
    drive_addr(k, 0);
    forever begin
      @(negedge HCLK); rdy = rdyo[k];
      @(posedge HCLK); #1;
      if (rdy) begin
        if (i >= seq.size()) begin hwdata = 32'h0; break; end
        dp = seq[i];
        if (dp.trans[1]) push_exp(k, dp);
        hwdata = (dp.trans[1] && dp.wr) ? hw(dp) : 32'h0;
        i++;
        drive_addr(k, i);
      end
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL timeout dut%0d", k);
        break;
      end
    end
    sel = 3'b000; htrans = 2'b00;
  endtask

  always @(negedge HCLK) begin
    exp_t        e;
    logic [31:0] er;
    for (int k = 0; k < 3; k++) begin
      e = '{1'b1, 1'b0, 1'b0, 1'b0, '0};
      if (!rst_n[k]) exq[k].delete();
      else if (exq[k].size() > 0) e = exq[k].pop_front();
      er = e.rd ? mword(k, e.v.addr) : 32'h0;
      if (!rdyo[k]) lowcnt[k]++;
      if (resp[k])  respcnt[k]++;
      checks++;
      if (rdyo[k] !== e.rdy || resp[k] !== e.resp || rdata[k] !== er) begin
        errors++;
        $display("FAIL cycle dut%0d t=%0t got rdy=%0b resp=%0b rdata=%h want rdy=%0b resp=%0b rdata=%h",
                 k, $time, rdyo[k], resp[k], rdata[k], e.rdy, e.resp, er);
      end
      if (e.rd && e.rdy) last_rd[k] = rdata[k];
      if (e.commit) mwrite(k, e.v);
    end
  end

  initial begin
    rst_n = 3'b111; sel = 3'b000; htrans = 2'b00; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
    for (int k = 0; k < 3; k++) begin lowcnt[k] = 0; respcnt[k] = 0; last_rd[k] = 32'h0; end
    #1 rst_n = 3'b000;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdy%0d", k),   32'(rdyo[k]), 32'd1);
      chk($sformatf("rst_resp%0d", k),  32'(resp[k]), 32'd0);
      chk($sformatf("rst_rdata%0d", k), rdata[k],     32'h0);
    end
    @(posedge HCLK); #3 rst_n = 3'b111;
    repeat (2) @(posedge HCLK);
    #1;

    // back-to-back write then read, no wait states
    seq.delete(); lowcnt[0] = 0;
    seq.push_back(mk(NS, 1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    seq.push_back(mk(NS, 0, 3'd2, 32'h10, 32'h0));
    run_seq(0);
    chk("raw_word", last_rd[0], 32'hDEAD_BEEF);
    chk("raw_nowait", 32'(lowcnt[0]), 32'd0);

    // byte lanes then halfword overlay
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd0, 32'h20, 32'h11));
    seq.push_back(mk(NS, 1, 3'd0, 32'h21, 32'h22));
    seq.push_back(mk(NS, 1, 3'd0, 32'h22, 32'h33));
    seq.push_back(mk(NS, 1, 3'd0, 32'h23, 32'h44));
    seq.push_back(mk(NS, 0, 3'd2, 32'h20, 32'h0));
    run_seq(0);
    chk("bytes", last_rd[0], 32'h4433_2211);
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd1, 32'h22, 32'hAAAA));
    seq.push_back(mk(NS, 0, 3'd1, 32'h22, 32'h0));
    seq.push_back(mk(NS, 0, 3'd2, 32'h20, 32'h0));
    run_seq(0);
    chk("half", last_rd[0], 32'hAAAA_2211);

    // wait states
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd2, 32'h40, 32'h1234_5678));
    run_seq(1);
    seq.delete(); lowcnt[1] = 0;
    seq.push_back(mk(NS, 0, 3'd2, 32'h40, 32'h0));
    run_seq(1);
    chk("ws_data", last_rd[1], 32'h1234_5678);
    chk("ws_low", 32'(lowcnt[1]), 32'd3);

    // illegal transfers, BUSY, read accepted during ERR2
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd2, 32'h00, 32'hCAFE_F00D));
    seq.push_back(mk(BZ, 1, 3'd2, 32'h00, 32'h0));
    run_seq(0);
    seq.delete(); respcnt[0] = 0;
    seq.push_back(mk(NS, 1, 3'd2, 32'h02, 32'hFFFF_FFFF));
    seq.push_back(mk(NS, 0, 3'd2, 32'h00, 32'h0));
    seq.push_back(mk(NS, 1, 3'd3, 32'h00, 32'h0BAD_0BAD));
    seq.push_back(mk(NS, 0, 3'd1, 32'h01, 32'h0));
    seq.push_back(mk(NS, 0, 3'd0, 32'h03, 32'h0));
    run_seq(0);
    chk("err_nowrite", last_rd[0], 32'hCAFE_F00D);
    chk("err_resp", 32'(respcnt[0]), 32'd6);

    // index wraps at 16 words, upper bits ignored
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd2, 32'h40, 32'h5A5A_5A5A));
    seq.push_back(mk(NS, 0, 3'd2, 32'h00, 32'h0));
    run_seq(2);
    chk("wrap", last_rd[2], 32'h5A5A_5A5A);
    seq.delete();
    seq.push_back(mk(NS, 0, 3'd2, 32'h1234_0000, 32'h0));
    run_seq(2);
    chk("wrap_hi", last_rd[2], 32'h5A5A_5A5A);

    // reset in the second wait cycle of a write
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd2, 32'h80, 32'h0102_0304));
    run_seq(1);
    seq.delete();
    seq.push_back(mk(NS, 1, 3'd2, 32'h80, 32'hFFFF_FFFF));
    fork
      run_seq(1);
      begin
        repeat (3) @(posedge HCLK);
        #2 chk("pre_rst_rdy", 32'(rdyo[1]), 32'd0);
        #1 rst_n[1] = 1'b0;
        #1;
        chk("arst_rdy",   32'(rdyo[1]), 32'd1);
        chk("arst_resp",  32'(resp[1]), 32'd0);
        chk("arst_rdata", rdata[1],     32'h0);
        repeat (2) @(posedge HCLK);
        #3 rst_n[1] = 1'b1;
      end
    join
    repeat (2) @(posedge HCLK);
    #1;
    seq.delete();
    seq.push_back(mk(NS, 0, 3'd2, 32'h80, 32'h0));
    run_seq(1);
    chk("rst_nowrite", last_rd[1], 32'h0102_0304);

    repeat (2) @(posedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
